// File: rtl/gf_inverse.sv
// GF(2^8) multiplicative inverse (a^254) for the AES datapath, computed by
// repeated square-and-multiply on one shared bit-serial multiplier.
module gf_inverse #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);

  typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] x;
  logic [7:0] r;
  logic [7:0] p;
  logic [2:0] bit_cnt;
  logic [2:0] step;
  logic [7:0] op_b;
  logic [7:0] p_shift;
  logic [7:0] prod;
  logic       last_bit;
  logic       accept;
  logic       release_out;

  // Shared multiplier: operand A is always x, operand B is x when squaring, r when multiplying.
  always_comb begin
    op_b        = (state == MUL) ? r : x;
    p_shift     = {p[6:0], 1'b0} ^ (p[7] ? POLY : 8'h00);
    prod        = p_shift ^ (op_b[bit_cnt] ? x : 8'h00);
    last_bit    = (bit_cnt == 3'd0);
    accept      = in_valid && in_ready;
    release_out = out_valid && out_ready;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SQ;
      SQ:   if (last_bit) state_next = MUL;
      MUL:  if (last_bit) state_next = (step == 3'd6) ? DONE : SQ;
      DONE: if (release_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= 8'h00;
      r        <= 8'h00;
      p        <= 8'h00;
      bit_cnt  <= 3'd0;
      step     <= 3'd0;
      out_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x       <= in_data;
            r       <= 8'h01;
            p       <= 8'h00;
            bit_cnt <= 3'd7;
            step    <= 3'd0;
          end
        end
        SQ: begin
          if (last_bit) begin
            x       <= prod;
            p       <= 8'h00;
            bit_cnt <= 3'd7;
          end else begin
            p       <= prod;
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        MUL: begin
          if (last_bit) begin
            r       <= prod;
            p       <= 8'h00;
            bit_cnt <= 3'd7;
            if (step == 3'd6) begin
              out_data <= prod;
            end else begin
              step <= step + 3'd1;
            end
          end else begin
            p       <= prod;
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inverse.sv
// Self-checking bench for gf_inverse against a polynomial-arithmetic model of
// GF(2^8) with the AES reduction polynomial.
module tb_gf_inverse;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int checks;
  int errors;
  logic [7:0] inv_table [256];

  gf_inverse #(.POLY(8'h1B)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schoolbook carry-less product, then long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) acc = acc ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (acc[i]) acc = acc ^ (16'h011B << (i - 8));
    return acc[7:0];
  endfunction

  task automatic build_model();
    inv_table[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      inv_table[a] = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv_table[a] = 8'(b);
    end
  endtask

  // Drives one operand and waits for out_valid; returns result, latency and whether in_ready rose mid-op.
  task automatic run_op(input logic [7:0] a, output logic [7:0] res, output int lat,
                        output logic ready_seen);
    int guard;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_data    = $urandom;
    lat        = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
  endtask

  task automatic finish_handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got %h want 00", out_data); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_known_values();
    logic [7:0] ops  [5];
    logic [7:0] want [5];
    logic [7:0] res;
    int         lat;
    logic       rs;
    ops  = '{8'h53, 8'h00, 8'h01, 8'h02, 8'hFF};
    want = '{8'hCA, 8'h00, 8'h01, 8'h8D, 8'h1C};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], res, lat, rs);
      checks++;
      if (res !== want[i] || res !== inv_table[ops[i]]) begin
        errors++;
        $display("[TB] FAIL known_%h got %h want %h", ops[i], res, want[i]);
      end
      checks++;
      if (lat != 112) begin errors++; $display("[TB] FAIL latency_%h got %0d want 112", ops[i], lat); end
      checks++;
      if (rs !== 1'b0) begin errors++; $display("[TB] FAIL in_ready_busy_%h got 1 want 0", ops[i]); end
      finish_handshake();
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] order [256];
    logic [7:0] tmp;
    logic [7:0] res;
    int         lat;
    int         j;
    logic       rs;
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      run_op(order[i], res, lat, rs);
      checks++;
      if (order[i] == 8'h00) begin
        if (res !== 8'h00) begin errors++; $display("[TB] FAIL exh_zero got %h want 00", res); end
      end else if (gf_mul(order[i], res) !== 8'h01 || res !== inv_table[order[i]]) begin
        errors++;
        $display("[TB] FAIL exh_%h got %h want %h", order[i], res, inv_table[order[i]]);
      end
      finish_handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a;
    logic [7:0] res;
    int         lat;
    logic       rs;
    a = 8'($urandom_range(255, 1));
    out_ready = 1'b0;
    run_op(a, res, lat, rs);
    checks++;
    if (res !== inv_table[a]) begin errors++; $display("[TB] FAIL bp_result got %h want %h", res, inv_table[a]); end
    in_valid = 1'b1;
    in_data  = ~a;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== inv_table[a] || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d got v=%b d=%h r=%b want v=1 d=%h r=0",
                 c, out_valid, out_data, in_ready, inv_table[a]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] res;
    int         lat;
    logic       rs;
    in_valid = 1'b1;
    in_data  = 8'h53;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    #2 rst_n = 1'b1;
    run_op(8'h02, res, lat, rs);
    checks++;
    if (res !== 8'h8D) begin errors++; $display("[TB] FAIL post_reset_result got %h want 8d", res); end
    checks++;
    if (lat != 112) begin errors++; $display("[TB] FAIL post_reset_latency got %0d want 112", lat); end
    finish_handshake();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [4];
    logic [7:0] got [$];
    int         acc_cyc [$];
    int         res_cyc [$];
    int         idx;
    int         cyc;
    logic       will_accept;
    for (int i = 0; i < 4; i++) ops[i] = 8'($urandom);
    idx       = 0;
    cyc       = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = ops[0];
    while (cyc < 600 && got.size() < 4) begin
      will_accept = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_accept) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 4) in_data = ops[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        got.push_back(out_data);
        res_cyc.push_back(cyc);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 4 || got.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2b_counts got acc=%0d res=%0d want 4/4", acc_cyc.size(), got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== inv_table[ops[i]]) begin
          errors++;
          $display("[TB] FAIL b2b_result_%0d got %h want %h", i, got[i], inv_table[ops[i]]);
        end
        if (i > 0) begin
          checks++;
          if (res_cyc[i] - res_cyc[i-1] != 114 || acc_cyc[i] - acc_cyc[i-1] != 114) begin
            errors++;
            $display("[TB] FAIL b2b_spacing_%0d got res=%0d acc=%0d want 114", i,
                     res_cyc[i] - res_cyc[i-1], acc_cyc[i] - acc_cyc[i-1]);
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    build_model();
    test_reset();
    test_known_values();
    test_exhaustive();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
